// File: rtl/dot_result_drain.sv
// dot_result_drain: buffers lane-parallel dot-product beats and drains them one lane per cycle.
// Latency: in_valid at edge t -> out_valid after edge t when empty; 1 word/cycle while out_ready.
// Backpressure: outputs hold while out_valid && !out_ready; beats arriving when full (no pop) are dropped, overflow sticks.
//
// Ports: clk/rst_n (sync active-low); in_valid/dot_in (one beat, lane 0 in low bits);
//   out_valid/out_ready/out_data/out_col/out_last (serialised stream, column-tagged);
//   level (occupied beats), overflow (sticky drop flag), acc_out/acc_valid (frame sum).
// Optional frame accumulator enabled by defining DOT_DRAIN_ACC_EN; otherwise acc outputs are 0.
module dot_result_drain #(
   parameter int LANES            = 4,
   parameter int INT_RESULT_WIDTH = 13,
   parameter int DEPTH            = 4,
   parameter int NUM_COLS         = 256,
   parameter int COL_W            = $clog2(NUM_COLS)
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      in_valid,
   input  logic [LANES*INT_RESULT_WIDTH-1:0]         dot_in,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic signed [INT_RESULT_WIDTH-1:0]        out_data,
   output logic [COL_W-1:0]                          out_col,
   output logic                                      out_last,
   output logic [$clog2(DEPTH+1)-1:0]                level,
   output logic                                      overflow,
   output logic signed [INT_RESULT_WIDTH+COL_W-1:0]  acc_out,
   output logic                                      acc_valid
);

   localparam int W      = INT_RESULT_WIDTH;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int LANE_W = $clog2(LANES);
   localparam int BEATS  = NUM_COLS / LANES;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LVL_W  = $clog2(DEPTH + 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic                ovf_q, ovf_d;

   // Beat storage is not reset: level/pointers define what is valid.
   logic [LANES*W-1:0]  data_q [DEPTH];
   logic [COL_W-1:0]    base_q [DEPTH];

   logic                hs, pop, push, full;
   logic [COL_W-1:0]    in_base;
   logic signed [W-1:0] word;
   logic [COL_W-1:0]    col;

   assign full    = (level_q == LVL_W'(DEPTH));
   assign hs      = out_valid && out_ready;
   assign pop     = hs && (lane_q == LANE_W'(LANES - 1));
   // A pop in the same cycle frees the slot, so a full buffer still accepts.
   assign push    = in_valid && (!full || pop);
   assign in_base = COL_W'(int'(beat_q) * LANES);

   assign word = data_q[rd_ptr_q][int'(lane_q)*W +: W];
   assign col  = base_q[rd_ptr_q] + COL_W'(lane_q);

   // Outputs are forced to 0 when nothing is presented so reset leaves every output at 0.
   assign out_valid = (state_q == SEND);
   assign out_data  = out_valid ? word : '0;
   assign out_col   = out_valid ? col : '0;
   assign out_last  = out_valid && (col == COL_W'(NUM_COLS - 1));
   assign level     = level_q;
   assign overflow  = ovf_q;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      lane_d   = lane_q;
      beat_d   = beat_q;
      level_d  = level_q;
      ovf_d    = ovf_q;

      case (state_q)
         IDLE: if (push) state_d = SEND;
         SEND: if (pop && !push && level_q == LVL_W'(1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Beat counter follows the source even for dropped beats to keep tags aligned.
      if (in_valid) begin
         beat_d = (beat_q == BEAT_W'(BEATS - 1)) ? '0 : beat_q + 1'b1;
         if (!push) ovf_d = 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (hs)   lane_d   = pop ? '0 : lane_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         lane_q   <= '0;
         beat_q   <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         lane_q   <= lane_d;
         beat_q   <= beat_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_ptr_q] <= dot_in;
         base_q[wr_ptr_q] <= in_base;
      end
   end

`ifdef DOT_DRAIN_ACC_EN
   logic signed [W+COL_W-1:0] sum_q, sum_d, acc_q;
   logic                      acc_vld_q;

   assign sum_d = sum_q + {{COL_W{word[W-1]}}, word};

   // The frame total includes the out_last word; the running sum restarts after it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q     <= '0;
         acc_q     <= '0;
         acc_vld_q <= 1'b0;
      end else begin
         acc_vld_q <= 1'b0;
         if (hs) begin
            if (out_last) begin
               acc_q     <= sum_d;
               acc_vld_q <= 1'b1;
               sum_q     <= '0;
            end else begin
               sum_q <= sum_d;
            end
         end
      end
   end

   assign acc_out   = acc_q;
   assign acc_valid = acc_vld_q;
`else
   assign acc_out   = '0;
   assign acc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_dot_result_drain.sv
module tb_dot_result_drain;

   logic               clk = 1'b0;
   logic               rst_n, in_valid, out_ready;
   logic [51:0]        dot_in;
   logic               out_valid, out_last, overflow, acc_valid;
   logic signed [12:0] out_data;
   logic [7:0]         out_col;
   logic [2:0]         level;
   logic signed [20:0] acc_out;

   int n_chk  = 0;
   int n_pass = 0;

   dot_result_drain dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .dot_in(dot_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_col(out_col), .out_last(out_last), .level(level), .overflow(overflow),
      .acc_out(acc_out), .acc_valid(acc_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic iv;
      logic rdy;
      int   d0, d1, d2, d3;
      logic ev;
      int   edata;
      int   ecol;
      int   elvl;
      logic eovf;
   } vec_t;

   vec_t tbl[15];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      else n_pass++;
   endtask

   function automatic logic [51:0] pack(input int a, input int b, input int c, input int d);
      logic [51:0] r;
      r[12:0]  = a[12:0];
      r[25:13] = b[12:0];
      r[38:26] = c[12:0];
      r[51:39] = d[12:0];
      return r;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // Push one beat whose lane values are 100 + column, given the base column.
   task automatic push_beat(input int base);
      in_valid = 1'b1;
      dot_in   = pack(100 + base, 101 + base, 102 + base, 103 + base);
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      int words, pulses, acc_seen, exp_col;

      // Reset held with in_valid asserted.
      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; dot_in = pack(1, 2, 3, 4);
      tick(); tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_acc_valid", acc_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_col", out_col, 0);
      rst_n = 1'b1; in_valid = 1'b0;

      // Each row: inputs applied across one edge, outputs expected after that edge.
      tbl[0]  = '{1, 1, -3, 5, 0, 7,           1, -3, 0, 1, 0};
      tbl[1]  = '{0, 1, 0, 0, 0, 0,            1,  5, 1, 1, 0};
      tbl[2]  = '{0, 1, 0, 0, 0, 0,            1,  0, 2, 1, 0};
      tbl[3]  = '{0, 1, 0, 0, 0, 0,            1,  7, 3, 1, 0};
      tbl[4]  = '{0, 1, 0, 0, 0, 0,            0,  0, 0, 0, 0};
      tbl[5]  = '{1, 0, 10, -20, 30, -40,      1, 10, 4, 1, 0};
      for (int i = 6; i < 11; i++)
         tbl[i] = '{0, 0, 0, 0, 0, 0,          1, 10, 4, 1, 0};
      tbl[11] = '{0, 1, 0, 0, 0, 0,            1, -20, 5, 1, 0};
      tbl[12] = '{0, 1, 0, 0, 0, 0,            1, 30, 6, 1, 0};
      tbl[13] = '{0, 1, 0, 0, 0, 0,            1, -40, 7, 1, 0};
      tbl[14] = '{0, 1, 0, 0, 0, 0,            0,  0, 0, 0, 0};

      for (int i = 0; i < 15; i++) begin
         in_valid  = tbl[i].iv;
         out_ready = tbl[i].rdy;
         dot_in    = pack(tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3);
         tick();
         chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].ev);
         chk($sformatf("vec%0d_data", i), out_data, tbl[i].edata);
         chk($sformatf("vec%0d_col", i), out_col, tbl[i].ecol);
         chk($sformatf("vec%0d_level", i), level, tbl[i].elvl);
         chk($sformatf("vec%0d_ovf", i), overflow, tbl[i].eovf);
      end
      in_valid = 1'b0;

      // Overflow: five beats into a 4-deep buffer with no drain.
      do_reset();
      for (int b = 0; b < 5; b++) push_beat(b * 4);
      chk("ovf_level", level, 4);
      chk("ovf_flag", overflow, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("ovf_col%0d", i), out_col, i);
         chk($sformatf("ovf_data%0d", i), out_data, 100 + i);
         tick();
      end
      chk("ovf_drained_valid", out_valid, 0);
      chk("ovf_drained_level", level, 0);
      push_beat(20);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ovf_next_col%0d", i), out_col, 20 + i);
         tick();
      end
      chk("ovf_sticky", overflow, 1);

      // Full buffer, push lands in the same cycle as the lane-3 pop.
      do_reset();
      for (int b = 0; b < 4; b++) push_beat(b * 4);
      out_ready = 1'b1;
      tick(); tick(); tick();
      chk("fp_lane3_col", out_col, 3);
      in_valid = 1'b1;
      dot_in   = pack(116, 117, 118, 119);
      tick();
      in_valid = 1'b0;
      chk("fp_level", level, 4);
      chk("fp_overflow", overflow, 0);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("fp_col%0d", i), out_col, 4 + i);
         chk($sformatf("fp_data%0d", i), out_data, 104 + i);
         tick();
      end
      chk("fp_drained", out_valid, 0);

      // Reset in the middle of a drain discards the buffered beat.
      push_beat(16);
      chk("mid_valid_before", out_valid, 1);
      do_reset();
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_level", level, 0);

      // Frame wrap: 65 beats of all +1, one beat every 4 cycles, always ready.
      out_ready = 1'b1;
      words = 0; pulses = 0; acc_seen = 0;
      for (int c = 0; c < 65 * 4 + 8; c++) begin
         in_valid = (c % 4 == 0) && (c < 65 * 4);
         dot_in   = pack(1, 1, 1, 1);
         tick();
         if (out_valid) begin
            exp_col = words % 256;
            chk($sformatf("fw_col%0d", words), out_col, exp_col);
            chk($sformatf("fw_last%0d", words), out_last, (exp_col == 255) ? 1 : 0);
            words++;
         end
         if (acc_valid) begin
            pulses++;
            acc_seen = int'(acc_out);
         end
      end
      in_valid = 1'b0;
      chk("fw_words", words, 260);
`ifdef DOT_DRAIN_ACC_EN
      chk("fw_acc_pulses", pulses, 1);
      chk("fw_acc_out", acc_seen, 256);
`else
      chk("fw_acc_pulses", pulses, 0);
      chk("fw_acc_out", acc_out, 0);
`endif
      chk("fw_overflow", overflow, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
